// File: rtl/osd_pkg.sv
// Shared types and width helpers for the OSD stream packer.
package osd_pkg;

   typedef enum logic [1:0] {
      S_SYNC  = 2'd0,
      S_IDLE  = 2'd1,
      S_FRAME = 2'd2
   } osd_state_e;

   function automatic int OSD_X_W(input int frame_w);
      return (frame_w > 1) ? $clog2(frame_w) : 1;
   endfunction

   // y must be able to hold FRAME_H itself for the end-of-frame line count
   function automatic int OSD_Y_W(input int frame_h);
      return (frame_h > 0) ? $clog2(frame_h + 1) : 1;
   endfunction

   function automatic int OSD_EOL_POS(input int data_w);
      return data_w;
   endfunction

   function automatic int OSD_SOF_POS(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int OSD_WORD_W(input int data_w);
      return data_w + 2;
   endfunction

endpackage

// File: rtl/osd_sync_fifo.sv
// Single-clock FIFO with a registered head word; an empty FIFO pushed into
// presents the new word on the very next cycle.
module osd_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 26
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d, remain;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             valid_q, valid_d;
   logic             do_push, do_pop;

   always_comb begin
      // full is judged on the pre-pop count, so a push at full is refused
      full     = (count_q == CW'(DEPTH));
      do_push  = push & ~full;
      do_pop   = pop & valid_q;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      remain   = count_q - CW'(do_pop);
      count_d  = remain + CW'(do_push);
      valid_d  = (count_d != '0);
      rdata_d  = rdata_q;
      if (valid_d) begin
         rdata_d = (do_push && remain == '0) ? wdata : mem[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
      end
   end

   assign empty = ~valid_q;
   assign rdata = rdata_q;

endmodule

// File: rtl/osd_stream_packer.sv
// Repacks the overlay fval/lval/dval stream into a tagged valid/ready stream.
// Define OSD_PACKER_GEOM_CHECK_EN to enable short-line / line-count checking.
module osd_stream_packer
   import osd_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int FRAME_W    = 640,
   parameter int FRAME_H    = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  pix_clk,
   input  logic                  rst,
   input  logic                  fval,
   input  logic                  lval,
   input  logic                  dval,
   input  logic [DATA_WIDTH-1:0] pix_in,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_sof,
   output logic                  m_eol,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  ovf_err,
   output logic                  geom_err,
   output logic                  frame_done
);
   localparam int X_W     = OSD_X_W(FRAME_W);
   localparam int WORD_W  = OSD_WORD_W(DATA_WIDTH);
   localparam int EOL_POS = OSD_EOL_POS(DATA_WIDTH);
   localparam int SOF_POS = OSD_SOF_POS(DATA_WIDTH);
   localparam logic [X_W-1:0] X_LAST = X_W'(FRAME_W - 1);

   osd_state_e        state_q, state_d;
   logic [X_W-1:0]    x_q, x_d, x_cur;
   logic              sof_arm_q, sof_arm_d, sof_cur;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   logic              start, in_frame, accept, eol_tag, push;
   logic              fifo_full, fifo_empty;
   logic [WORD_W-1:0] push_word, head_word;

`ifdef OSD_PACKER_GEOM_CHECK_EN
   localparam int Y_W = OSD_Y_W(FRAME_H);
   localparam logic [Y_W-1:0] Y_END = Y_W'(FRAME_H);

   logic [Y_W-1:0] y_q, y_d, y_cur;
   logic           geom_q, geom_d;
   logic           lval_q;

   // saturate so runaway frames cannot wrap back into the legal range
   function automatic logic [Y_W-1:0] y_step(input logic [Y_W-1:0] y);
      return (y == Y_END) ? y : y + 1'b1;
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      start   = 1'b0;
      case (state_q)
         S_SYNC:  if (!fval) state_d = S_IDLE;
         S_IDLE:  if (fval) begin
                     state_d = S_FRAME;
                     start   = 1'b1;
                  end
         S_FRAME: if (!fval) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
         default: state_d = S_SYNC;
      endcase

      // the frame-start cycle already sees cleared counters and flags
      in_frame  = start | (state_q == S_FRAME);
      accept    = in_frame & fval & lval & dval;
      x_cur     = start ? '0 : x_q;
      sof_cur   = start | sof_arm_q;
      ovf_d     = ovf_q & ~start;
      eol_tag   = accept & (x_cur == X_LAST);
      push      = accept;
      sof_arm_d = sof_cur & ~accept;
      x_d       = x_cur;
      if (accept) begin
         x_d = eol_tag ? '0 : x_cur + 1'b1;
      end

`ifdef OSD_PACKER_GEOM_CHECK_EN
      y_cur  = start ? '0 : y_q;
      y_d    = y_cur;
      geom_d = geom_q & ~start;
      if (accept) begin
         if (eol_tag) y_d = y_step(y_cur);
         if (y_cur >= Y_END) begin
            push   = 1'b0;
            geom_d = 1'b1;
         end
      end
      if ((state_q == S_FRAME) && lval_q && !lval && (x_q != '0)) begin
         geom_d = 1'b1;
         x_d    = '0;
         y_d    = y_step(y_q);
      end
      if (done_d && (y_d != Y_END)) geom_d = 1'b1;
`endif

      // overflowed pixels still moved the counters above, keeping tags aligned
      if (push && fifo_full) ovf_d = 1'b1;
      push_word = {sof_cur, eol_tag, pix_in};
   end

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         state_q   <= S_SYNC;
         x_q       <= '0;
         sof_arm_q <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef OSD_PACKER_GEOM_CHECK_EN
         y_q       <= '0;
         geom_q    <= 1'b0;
         lval_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         sof_arm_q <= sof_arm_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
`ifdef OSD_PACKER_GEOM_CHECK_EN
         y_q       <= y_d;
         geom_q    <= geom_d;
         lval_q    <= lval;
`endif
      end
   end

   osd_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk   (pix_clk),
      .srst  (rst),
      .push  (push),
      .wdata (push_word),
      .pop   (m_ready),
      .full  (fifo_full),
      .empty (fifo_empty),
      .rdata (head_word)
   );

   assign m_valid    = ~fifo_empty;
   assign m_data     = head_word[DATA_WIDTH-1:0];
   assign m_eol      = head_word[EOL_POS];
   assign m_sof      = head_word[SOF_POS];
   assign ovf_err    = ovf_q;
   assign frame_done = done_q;
`ifdef OSD_PACKER_GEOM_CHECK_EN
   assign geom_err   = geom_q;
`else
   assign geom_err   = 1'b0;
`endif

endmodule

// File: tb/tb_osd_stream_packer.sv
// Scoreboard bench for osd_stream_packer on an 8x4 frame with a 16-deep FIFO.
module tb_osd_stream_packer;
   localparam int DW    = 24;
   localparam int W     = 8;
   localparam int H     = 4;
   localparam int DEPTH = 16;
`ifdef OSD_PACKER_GEOM_CHECK_EN
   localparam bit GEOM_EN = 1'b1;
`else
   localparam bit GEOM_EN = 1'b0;
`endif

   logic          pix_clk = 1'b0;
   logic          rst     = 1'b1;
   logic          fval    = 1'b0;
   logic          lval    = 1'b0;
   logic          dval    = 1'b0;
   logic [DW-1:0] pix_in  = '0;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic          m_sof, m_eol, m_valid;
   logic          ovf_err, geom_err, frame_done;

   int n_checks = 0;
   int n_pass   = 0;
   int words = 0, sof_seen = 0, eol_seen = 0, done_seen = 0;
   bit armed = 1'b0;

   // reference model state (values after the most recent clock edge)
   logic [DW+1:0] exp_q[$];
   logic [DW+1:0] mdl_word, got_word;
   int  mdl_state = 0;
   int  mdl_x = 0, mdl_y = 0, mdl_cnt = 0;
   bit  mdl_sof_arm = 0, mdl_lval_q = 0, mdl_ovf = 0, mdl_geom = 0, mdl_done = 0;
   bit  mdl_start, mdl_push, mdl_pop, mdl_eol;

   always #5 pix_clk = ~pix_clk;

   osd_stream_packer #(
      .DATA_WIDTH (DW),
      .FRAME_W    (W),
      .FRAME_H    (H),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .pix_clk    (pix_clk),
      .rst        (rst),
      .fval       (fval),
      .lval       (lval),
      .dval       (dval),
      .pix_in     (pix_in),
      .m_data     (m_data),
      .m_sof      (m_sof),
      .m_eol      (m_eol),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .ovf_err    (ovf_err),
      .geom_err   (geom_err),
      .frame_done (frame_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge pix_clk) begin
      if (armed) begin
         check_eq("m_valid", 32'(m_valid), 32'(mdl_cnt != 0));
         check_eq("ovf_err", 32'(ovf_err), 32'(mdl_ovf));
         check_eq("geom_err", 32'(geom_err), 32'(mdl_geom));
         check_eq("frame_done", 32'(frame_done), 32'(mdl_done));
         if (m_valid && m_ready) begin
            got_word = {m_sof, m_eol, m_data};
            if (exp_q.size() > 0) check_eq("word", 32'(got_word), 32'(exp_q.pop_front()));
            else check_eq("queue_depth", 32'(exp_q.size()), 32'd1);
            $display("word %0d data=%06h sof=%0b eol=%0b", words, m_data, m_sof, m_eol);
            words++;
            if (m_sof) sof_seen++;
            if (m_eol) eol_seen++;
         end
         if (frame_done) done_seen++;

         // predict the effect of the coming edge from the inputs now applied
         if (rst) begin
            exp_q.delete();
            mdl_state = 0; mdl_x = 0; mdl_y = 0; mdl_cnt = 0;
            mdl_sof_arm = 0; mdl_lval_q = 0; mdl_ovf = 0; mdl_geom = 0; mdl_done = 0;
         end else begin
            mdl_start = (mdl_state == 1) && fval;
            if (mdl_start) begin
               mdl_x = 0; mdl_y = 0; mdl_sof_arm = 1; mdl_ovf = 0; mdl_geom = 0;
            end
            mdl_push = 0;
            mdl_pop  = (mdl_cnt > 0) && m_ready;
            mdl_done = 0;
            if ((mdl_state == 2 || mdl_start) && fval && lval && dval) begin
               mdl_eol  = (mdl_x == W - 1);
               mdl_word = {mdl_sof_arm, mdl_eol, pix_in};
               mdl_sof_arm = 0;
               if (GEOM_EN && mdl_y >= H) mdl_geom = 1;
               else if (mdl_cnt >= DEPTH) mdl_ovf = 1;
               else mdl_push = 1;
               if (mdl_eol) begin
                  mdl_x = 0;
                  if (mdl_y < H) mdl_y++;
               end else begin
                  mdl_x++;
               end
            end
            if (GEOM_EN && mdl_state == 2 && mdl_lval_q && !lval && mdl_x != 0) begin
               mdl_geom = 1;
               mdl_x = 0;
               if (mdl_y < H) mdl_y++;
            end
            case (mdl_state)
               0: if (!fval) mdl_state = 1;
               1: if (fval) mdl_state = 2;
               default: if (!fval) begin
                  mdl_state = 1;
                  mdl_done  = 1;
                  if (GEOM_EN && mdl_y != H) mdl_geom = 1;
               end
            endcase
            if (mdl_push) exp_q.push_back(mdl_word);
            mdl_cnt = mdl_cnt + int'(mdl_push) - int'(mdl_pop);
            mdl_lval_q = lval;
         end
      end
   end

   task automatic cyc();
      @(posedge pix_clk);
      #1;
   endtask

   // short_line < 0: full frame; ready low for pixel index < ready_lo_until; rst pulse at pixel rst_at
   task automatic send_frame(input int short_line, input int short_len,
                             input int ready_lo_until, input int rst_at);
      int k;
      int len;
      k = 0;
      fval = 1'b1;
      cyc(); cyc();
      for (int ln = 0; ln < H; ln++) begin
         len = (ln == short_line) ? short_len : W;
         for (int p = 0; p < len; p++) begin
            lval    = 1'b1;
            dval    = 1'b1;
            pix_in  = DW'($urandom);
            m_ready = (k >= ready_lo_until);
            rst     = (k == rst_at);
            cyc();
            k++;
         end
         lval = 1'b0;
         dval = 1'b0;
         rst  = 1'b0;
         cyc(); cyc();
      end
      fval = 1'b0;
      cyc(); cyc(); cyc();
   endtask

   task automatic drain();
      m_ready = 1'b1;
      repeat (40) cyc();
   endtask

   int s_words, s_sof, s_eol, s_done;

   task automatic snap();
      s_words = words; s_sof = sof_seen; s_eol = eol_seen; s_done = done_seen;
   endtask

   initial begin
      rst = 1'b1;
      cyc();
      armed = 1'b1;
      cyc(); cyc();
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_m_data", 32'(m_data), 32'd0);
      check_eq("rst_m_sof", 32'(m_sof), 32'd0);
      check_eq("rst_m_eol", 32'(m_eol), 32'd0);
      check_eq("rst_flags", 32'({ovf_err, geom_err, frame_done}), 32'd0);
      rst = 1'b0;
      cyc(); cyc();

      snap();
      send_frame(-1, 0, 0, -1);
      drain();
      check_eq("clean_words", 32'(words - s_words), 32'd32);
      check_eq("clean_sof", 32'(sof_seen - s_sof), 32'd1);
      check_eq("clean_eol", 32'(eol_seen - s_eol), 32'd4);
      check_eq("clean_done", 32'(done_seen - s_done), 32'd1);
      check_eq("clean_ovf", 32'(ovf_err), 32'd0);

      snap();
      send_frame(-1, 0, 1000, -1);
      check_eq("bp_ovf_end", 32'(ovf_err), 32'd1);
      drain();
      check_eq("bp_words", 32'(words - s_words), 32'd16);
      check_eq("bp_sof", 32'(sof_seen - s_sof), 32'd1);
      check_eq("bp_ovf_held", 32'(ovf_err), 32'd1);

      snap();
      send_frame(-1, 0, 0, 12);
      drain();
      check_eq("rst_frame_words", 32'(words - s_words), 32'd12);
      check_eq("rst_frame_done", 32'(done_seen - s_done), 32'd0);
      snap();
      send_frame(-1, 0, 0, -1);
      drain();
      check_eq("relock_words", 32'(words - s_words), 32'd32);
      check_eq("relock_sof", 32'(sof_seen - s_sof), 32'd1);
      check_eq("relock_ovf", 32'(ovf_err), 32'd0);

      snap();
      send_frame(-1, 0, 16, -1);
      drain();
      check_eq("fullpop_words", 32'(words - s_words), 32'd31);
      check_eq("fullpop_ovf", 32'(ovf_err), 32'd1);

`ifdef OSD_PACKER_GEOM_CHECK_EN
      snap();
      send_frame(1, 5, 0, -1);
      drain();
      check_eq("short_geom", 32'(geom_err), 32'd1);
      check_eq("short_words", 32'(words - s_words), 32'd29);
      check_eq("short_eol", 32'(eol_seen - s_eol), 32'd3);
      check_eq("short_sof", 32'(sof_seen - s_sof), 32'd1);
`else
      check_eq("geom_tied", 32'(geom_err), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
